tern_sar_ctrl: RTL and testbench

Balanced-ternary successive-approximation controller for the ADC/DAC test chip. It drives the 6-trit ternary DAC and reads the two analog comparators (compr1/compr2). It resolves one trit per step, MSB first, and presents the result as 2-bit trit codes to the ALU/output mux. It is the sequential stage that produces tern_dac and consumes compr1/compr2.

---
 rtl/tern_sar_pkg.sv | 18 +
 rtl/tern_trit_dac_map.sv | 9 +
 rtl/tern_sar_ctrl.sv | 144 ++++++++++++++
 tb/tb_tern_sar_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tern_sar_pkg.sv
// tern_sar_pkg: trit/DAC encodings and FSM states for the ternary SAR controller (PH_OVR with TERN_SAR_OVERRANGE_EN)
package tern_sar_pkg;
  localparam logic [1:0] TRIT_POS  = 2'b11;
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_NEG  = 2'b10;
  localparam logic [2:0] DAC_POS   = 3'b110;
  localparam logic [2:0] DAC_ZERO  = 3'b101;
  localparam logic [2:0] DAC_NEG   = 3'b000;
  typedef enum logic [2:0] {
    IDLE,
    PH_HI,
    PH_LO,
`ifdef TERN_SAR_OVERRANGE_EN
    PH_OVR,
`endif
    DONE
  } state_e;
endpackage

// File: rtl/tern_trit_dac_map.sv
// tern_trit_dac_map: 2-bit trit code to 3-bit DAC drive
module tern_trit_dac_map
  import tern_sar_pkg::*;
(
  input  logic [1:0] code_i,
  output logic [2:0] dac_o
);
  always_comb dac_o = code_i == TRIT_POS ? DAC_POS : code_i == TRIT_NEG ? DAC_NEG : DAC_ZERO;
endmodule

// File: rtl/tern_sar_ctrl.sv
// tern_sar_ctrl: balanced-ternary SAR controller, one trit per step MSB first
// Optional overrange check phase enabled by TERN_SAR_OVERRANGE_EN
module tern_sar_ctrl
  import tern_sar_pkg::*;
#(
  parameter int N_TRITS       = 6,
  parameter int SETTLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   compr1,
  input  logic                   compr2,
  output logic                   busy,
  output logic                   done,
  output logic [2*N_TRITS-1:0]   result,
  output logic                   result_valid,
  output logic [3*N_TRITS-1:0]   tern_dac
`ifdef TERN_SAR_OVERRANGE_EN
  ,
  output logic                   overrange
`endif
);
  localparam int P  = SETTLE_CYCLES + SYNC_STAGES;
  localparam int IW = N_TRITS > 1 ? $clog2(N_TRITS) : 1;
  localparam int CW = $clog2(P);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] s1_q, s2_q;
  logic [2*N_TRITS-1:0] res_q, res_d, code_d;
  logic [3*N_TRITS-1:0] tern_dac_q, dac_d;
  logic busy_q, done_q, rv_q, rv_d, ovr_q, ovr_d, ld, dec, last, c1, c2;
  // Trial word: decided trits above idx, zero at idx, fill value below
  function automatic logic [2*N_TRITS-1:0] trial(input logic [2*N_TRITS-1:0] r, input int idx,
                                                 input logic [1:0] fill);
    logic [2*N_TRITS-1:0] t;
    for (int j = 0; j < N_TRITS; j++) t[2*j +: 2] = j > idx ? r[2*j +: 2] : j == idx ? TRIT_ZERO : fill;
    return t;
  endfunction
  for (genvar g = 0; g < N_TRITS; g++) begin : g_map
    tern_trit_dac_map u_map (.code_i(code_d[2*g +: 2]), .dac_o(dac_d[3*g +: 3]));
  end
  assign c1   = s1_q[SYNC_STAGES-1];
  assign c2   = s2_q[SYNC_STAGES-1];
  assign last = cnt_q == CW'(P - 1);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    res_d   = res_q;
    code_d  = '0;
    ld      = 1'b0;
    dec     = 1'b0;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = PH_HI;
        idx_d   = IW'(N_TRITS - 1);
        cnt_d   = '0;
        res_d   = '0;
        ld      = 1'b1;
        code_d  = trial('0, N_TRITS - 1, TRIT_POS);
        ovr_d   = 1'b0;
      end
      PH_HI: if (last) begin
        if (c1) begin
          res_d[2*idx_q +: 2] = TRIT_POS;
          dec = 1'b1;
        end else begin
          state_d = PH_LO;
          cnt_d   = '0;
          ld      = 1'b1;
          code_d  = trial(res_q, int'(idx_q), TRIT_NEG);
        end
      end
      PH_LO: if (last) begin
        res_d[2*idx_q +: 2] = c2 ? TRIT_NEG : TRIT_ZERO;
        dec = 1'b1;
      end
`ifdef TERN_SAR_OVERRANGE_EN
      PH_OVR: if (last) begin
        state_d = DONE;
        ovr_d   = res_q[1:0] == TRIT_POS ? c1 : c2;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (dec) begin
      cnt_d = '0;
      ld    = 1'b1;
      if (idx_q == '0) begin
        code_d = res_d;
`ifdef TERN_SAR_OVERRANGE_EN
        state_d = (res_d == {N_TRITS{TRIT_POS}} || res_d == {N_TRITS{TRIT_NEG}}) ? PH_OVR : DONE;
`else
        state_d = DONE;
`endif
      end else begin
        state_d = PH_HI;
        idx_d   = idx_q - IW'(1);
        code_d  = trial(res_d, int'(idx_q) - 1, TRIT_POS);
      end
    end
    rv_d = state_d == DONE ? 1'b1 : (state_q == IDLE && start) ? 1'b0 : rv_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= IW'(N_TRITS - 1);
      cnt_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      res_q      <= '0;
      tern_dac_q <= {N_TRITS{DAC_ZERO}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rv_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      s1_q       <= {s1_q[SYNC_STAGES-2:0], compr1};
      s2_q       <= {s2_q[SYNC_STAGES-2:0], compr2};
      res_q      <= res_d;
      tern_dac_q <= ld ? dac_d : tern_dac_q;
      busy_q     <= state_d != IDLE;
      done_q     <= state_d == DONE;
      rv_q       <= rv_d;
      ovr_q      <= ovr_d;
    end
  end
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign tern_dac     = tern_dac_q;
`ifdef TERN_SAR_OVERRANGE_EN
  assign overrange    = ovr_q;
`endif
endmodule

// File: tb/tb_tern_sar_ctrl.sv
// tb_tern_sar_ctrl: scoreboard bench for tern_sar_ctrl with a behavioural comparator model
module tb_tern_sar_ctrl;
  localparam int N = 6;
  localparam int P = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, compr1 = 1'b0, compr2 = 1'b0, n1 = 1'b0, n2 = 1'b0;
  logic busy, done, result_valid;
  logic [2*N-1:0] result;
  logic [3*N-1:0] tern_dac;
  logic ovr;
`ifdef TERN_SAR_OVERRANGE_EN
  logic overrange;
  assign ovr = overrange;
`else
  assign ovr = 1'b0;
`endif
  int vin = 0, cyc = 0, t_start = 0, checks = 0, errors = 0;
  typedef struct {logic [2*N-1:0] res; int lat; logic ovr;} exp_t;
  exp_t q[$];

  tern_sar_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .compr1(compr1), .compr2(compr2),
    .busy(busy), .done(done), .result(result), .result_valid(result_valid), .tern_dac(tern_dac)
`ifdef TERN_SAR_OVERRANGE_EN
    , .overrange(overrange)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dac_val(input logic [3*N-1:0] d);
    int v = 0;
    for (int j = N - 1; j >= 0; j--) v = v * 3 + (d[3*j +: 3] == 3'b110 ? 1 : d[3*j +: 3] == 3'b000 ? -1 : 0);
    return v;
  endfunction

  // Comparator model: decisions reflect the DAC level one cycle earlier
  always @(negedge clk) begin
    n1 <= vin > dac_val(tern_dac);
    n2 <= vin < dac_val(tern_dac);
  end
  always @(posedge clk) begin
    compr1 <= n1;
    compr2 <= n2;
  end

  function automatic logic [2*N-1:0] bt(input int vi);
    logic [2*N-1:0] r;
    int v, m;
    v = vi > 364 ? 364 : vi < -364 ? -364 : vi;
    for (int j = 0; j < N; j++) begin
      m = ((v % 3) + 3) % 3;
      r[2*j +: 2] = m == 0 ? 2'b00 : m == 1 ? 2'b11 : 2'b10;
      v = m == 0 ? v / 3 : m == 1 ? (v - 1) / 3 : (v + 1) / 3;
    end
    return r;
  endfunction

  function automatic logic [3*N-1:0] dmap(input logic [2*N-1:0] r);
    logic [3*N-1:0] d;
    for (int j = 0; j < N; j++) d[3*j +: 3] = r[2*j +: 2] == 2'b11 ? 3'b110 : r[2*j +: 2] == 2'b10 ? 3'b000 : 3'b101;
    return d;
  endfunction

  task automatic push(input int v);
    exp_t e;
    e.res = bt(v);
    e.lat = 1;
    for (int j = 0; j < N; j++) e.lat += e.res[2*j +: 2] == 2'b11 ? P : 2 * P;
    e.ovr = 1'b0;
`ifdef TERN_SAR_OVERRANGE_EN
    if (e.res == {N{2'b11}} || e.res == {N{2'b10}}) e.lat += P;
    e.ovr = vin > 364 || vin < -364;
`endif
    q.push_back(e);
  endtask

  task automatic wait_check(input string name, input int poke);
    exp_t e;
    int n = 1;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      start = poke != 0 && n == poke;
    end
    start = 1'b0;
    checks++;
    if (n >= 200 || q.size() == 0) begin
      errors++;
      $display("FAIL %s timeout: done not seen within %0d cycles, queue %0d", name, n, q.size());
      return;
    end
    e = q.pop_front();
    checks += 6;
    if (result !== e.res) begin errors++; $display("FAIL %s result got %h exp %h", name, result, e.res); end
    if (cyc - t_start !== e.lat) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, cyc - t_start, e.lat); end
    if (result_valid !== 1'b1) begin errors++; $display("FAIL %s result_valid got %b exp 1", name, result_valid); end
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy in done got %b exp 1", name, busy); end
    if (tern_dac !== dmap(e.res)) begin errors++; $display("FAIL %s tern_dac got %h exp %h", name, tern_dac, dmap(e.res)); end
    if (ovr !== e.ovr) begin errors++; $display("FAIL %s overrange got %b exp %b", name, ovr, e.ovr); end
  endtask

  task automatic run_conv(input int v, input string name, input int poke);
    logic [2*N-1:0] exp_res;
    @(negedge clk);
    vin = v;
    start = 1'b1;
    t_start = cyc;
    push(v);
    exp_res = q[q.size() - 1].res;
    @(negedge clk);
    start = 1'b0;
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy at cycle 1 got %b exp 1", name, busy); end
    if (result_valid !== 1'b0) begin errors++; $display("FAIL %s result_valid at cycle 1 got %b exp 0", name, result_valid); end
    wait_check(name, poke);
    @(negedge clk);
    checks += 4;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done after pulse got %b exp 0", name, done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy after done got %b exp 0", name, busy); end
    if (result_valid !== 1'b1) begin errors++; $display("FAIL %s result_valid hold got %b exp 1", name, result_valid); end
    if (result !== exp_res) begin errors++; $display("FAIL %s result hold got %h exp %h", name, result, exp_res); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b exp 0", done); end
    if (result !== '0) begin errors++; $display("FAIL reset result got %h exp 0", result); end
    if (result_valid !== 1'b0) begin errors++; $display("FAIL reset result_valid got %b exp 0", result_valid); end
    if (tern_dac !== {N{3'b101}}) begin errors++; $display("FAIL reset tern_dac got %h exp %h", tern_dac, {N{3'b101}}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    vin = 364;
    start = 1'b1;
    t_start = cyc;
    push(364);
    push(364);
    @(negedge clk);
    wait_check("b2b_first", 1);
    start = 1'b1;
    t_start = cyc + 1;
    repeat (2) @(negedge clk);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b restart busy got %b exp 1", busy); end
    if (result_valid !== 1'b0) begin errors++; $display("FAIL b2b restart result_valid got %b exp 0", result_valid); end
    start = 1'b0;
    wait_check("b2b_second", 0);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    vin = -200;
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k < 16; k++) begin
      start = k == 5 || k == 14;
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL midrst done got %b exp 0", done); end
    if (result_valid !== 1'b0) begin errors++; $display("FAIL midrst result_valid got %b exp 0", result_valid); end
    if (result !== '0) begin errors++; $display("FAIL midrst result got %h exp 0", result); end
    if (tern_dac !== {N{3'b101}}) begin errors++; $display("FAIL midrst tern_dac got %h exp %h", tern_dac, {N{3'b101}}); end
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst activity after reset got %0d cycles exp 0", seen); end
  endtask

  initial begin
    test_reset();
    run_conv(0, "zero", 0);
    run_conv(364, "max", 0);
    run_conv(5, "p5", 0);
    run_conv(-200, "m200", 0);
    run_conv(-364, "min", 0);
    run_conv(5, "start_ignored", 10);
    test_back_to_back();
    test_reset_mid();
    run_conv(400, "over_pos", 0);
    run_conv(-400, "over_neg", 0);
    for (int i = 0; i < 4; i++) run_conv(int'($urandom_range(728)) - 364, "random", 0);
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL scoreboard leftover got %0d exp 0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
